// File: rtl/led_pattern_pkg.sv
// Shared types and limits for the LED pattern generator.
// Mode encoding is what software writes into the per-channel mode field.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_BLINK   = 2'b01,
    MODE_PWM     = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int MODE_W = 2;
  localparam int MIN_CH = 1;
  localparam int MAX_CH = 8;

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode mux, breathe ramp state and the registered LED flop.
// LED output lags its inputs by one cycle; breathe state advances only on step ticks while running.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_mode,
  input  logic [PWM_W-1:0] i_duty,
  input  logic [PWM_W-1:0] i_pwm_cnt,
  input  logic             i_blink_bit,
  input  logic             i_step_tick,
  input  logic             i_run,
  output logic             o_led
);

  localparam logic [PWM_W-1:0] DUTY_MAX  = '1;
  localparam logic [PWM_W-1:0] DUTY_ZERO = '0;
  localparam logic [PWM_W-1:0] DUTY_ONE  = {{(PWM_W-1){1'b0}}, 1'b1};
  localparam logic [PWM_W-1:0] DUTY_TOP1 = DUTY_MAX - DUTY_ONE;

  logic [PWM_W-1:0] r_bduty;
  dir_e             r_dir;
  logic             r_led;

  logic [PWM_W-1:0] w_bduty_nxt;
  dir_e             w_dir_nxt;
  logic             w_led_nxt;
  mode_e            w_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bduty <= '0;
      r_dir   <= DIR_UP;
      r_led   <= 1'b0;
    end else begin
      r_bduty <= w_bduty_nxt;
      r_dir   <= w_dir_nxt;
      r_led   <= w_led_nxt;
    end
  end

  // Without run everything holds except the LED, which is forced dark.
  always_comb begin
    w_bduty_nxt = r_bduty;
    w_dir_nxt   = r_dir;
    w_led_nxt   = 1'b0;
    w_mode      = mode_e'(i_mode);
    if (i_run) begin
      unique case (w_mode)
        MODE_OFF: begin
          w_bduty_nxt = '0;
          w_dir_nxt   = DIR_UP;
        end
        MODE_BLINK: begin
          w_led_nxt   = i_blink_bit;
          w_bduty_nxt = '0;
          w_dir_nxt   = DIR_UP;
        end
        MODE_PWM: begin
          w_led_nxt   = (i_pwm_cnt < i_duty);
          w_bduty_nxt = '0;
          w_dir_nxt   = DIR_UP;
        end
        MODE_BREATHE: begin
          w_led_nxt = (i_pwm_cnt < r_bduty);
          // Direction flips on the same update that lands on an endpoint, so the ramp never wraps.
          if (i_step_tick) begin
            if (r_dir == DIR_UP) begin
              if (r_bduty != DUTY_MAX) w_bduty_nxt = r_bduty + DUTY_ONE;
              if (r_bduty >= DUTY_TOP1) w_dir_nxt = DIR_DOWN;
            end else begin
              if (r_bduty != DUTY_ZERO) w_bduty_nxt = r_bduty - DUTY_ONE;
              if (r_bduty <= DUTY_ONE) w_dir_nxt = DIR_UP;
            end
          end
        end
      endcase
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: lock synchroniser, shared blink/PWM counters, NUM_CH channel instances.
// LEDs lag mode/duty by one cycle and lag LOCKED by three; no handshake, inputs are sampled every cycle.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 25,
  parameter int PWM_W  = 8,
  parameter int STEP_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    locked,
  input  logic                    enable,
  input  logic [MODE_W*NUM_CH-1:0] mode,
  input  logic [PWM_W*NUM_CH-1:0] duty,
  output logic [NUM_CH-1:0]       led,
  output logic                    running
);

  if (NUM_CH < MIN_CH || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("led_pattern_gen: NUM_CH out of range");
  end
  if (CNT_W <= NUM_CH || STEP_W > CNT_W) begin : g_bad_cnt_w
    $error("led_pattern_gen: CNT_W too small for NUM_CH or STEP_W");
  end

  logic              r_lk_meta;
  logic              r_lk_s;
  logic              r_running;
  logic [CNT_W-1:0]  r_count;
  logic [PWM_W-1:0]  r_pwm_cnt;
  logic              w_run;
  logic              w_step_tick;

  // LOCKED is asynchronous to clk; two flops before it may gate anything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lk_meta <= 1'b0;
      r_lk_s    <= 1'b0;
    end else begin
      r_lk_meta <= locked;
      r_lk_s    <= r_lk_meta;
    end
  end

  assign w_run       = r_lk_s & enable;
  assign w_step_tick = &r_count[STEP_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_running <= 1'b0;
      r_count   <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_running <= w_run;
      if (w_run) begin
        r_count   <= r_count + 1'b1;
        r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end
    end
  end

  assign running = r_running;

  // Channel i blinks from count bit CNT_W-1-i, doubling the rate per channel.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_channel #(
      .PWM_W(PWM_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_mode     (mode[MODE_W*i +: MODE_W]),
      .i_duty     (duty[PWM_W*i +: PWM_W]),
      .i_pwm_cnt  (r_pwm_cnt),
      .i_blink_bit(r_count[CNT_W-1-i]),
      .i_step_tick(w_step_tick),
      .i_run      (w_run),
      .o_led      (led[i])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: cycle-level reference built from run-cycle count and breathe tick count.
// The breathe level is a triangle function of ticks since entering the mode.
module tb_led_pattern_gen;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 6;
  localparam int PWM_W  = 3;
  localparam int STEP_W = 2;
  localparam int CNT_MOD  = 1 << CNT_W;
  localparam int PWM_MOD  = 1 << PWM_W;
  localparam int STEP_MOD = 1 << STEP_W;
  localparam int DMAX     = PWM_MOD - 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    locked;
  logic                    enable;
  logic [2*NUM_CH-1:0]     mode;
  logic [PWM_W*NUM_CH-1:0] duty;
  logic [NUM_CH-1:0]       led;
  logic                    running;

  int errors = 0;
  int checks = 0;

  int             m_n;
  bit             m_lk1;
  bit             m_lk2;
  logic [NUM_CH-1:0] m_led;
  logic           m_running;
  int             m_ticks[NUM_CH];

  always #5 clk = ~clk;

  led_pattern_gen #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PWM_W(PWM_W), .STEP_W(STEP_W)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked), .enable(enable),
    .mode(mode), .duty(duty), .led(led), .running(running)
  );

  function automatic int tri_level(int t);
    int p;
    p = t % (2 * DMAX);
    return (p <= DMAX) ? p : (2 * DMAX - p);
  endfunction

  // Advance reference and DUT by one clock; sample 1 time unit after the edge.
  task automatic cycle();
    bit                run;
    logic [NUM_CH-1:0] nl;
    int                nt[NUM_CH];
    int                md;
    int                dt;
    run = m_lk2 && enable;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      md = int'(mode[2*ch +: 2]);
      dt = int'(duty[PWM_W*ch +: PWM_W]);
      nt[ch] = m_ticks[ch];
      nl[ch] = 1'b0;
      if (run) begin
        case (md)
          1: nl[ch] = ((m_n >> (CNT_W - 1 - ch)) & 1) != 0;
          2: nl[ch] = (m_n % PWM_MOD) < dt;
          3: nl[ch] = (m_n % PWM_MOD) < tri_level(m_ticks[ch]);
          default: nl[ch] = 1'b0;
        endcase
        if (md == 3) begin
          if (m_n % STEP_MOD == STEP_MOD - 1) nt[ch] = m_ticks[ch] + 1;
        end else begin
          nt[ch] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_n = 0; m_lk1 = 0; m_lk2 = 0; m_led = '0; m_running = 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) m_ticks[ch] = 0;
    end else begin
      m_led     = nl;
      m_running = run;
      m_lk2     = m_lk1;
      m_lk1     = locked;
      if (run) m_n = (m_n + 1) % CNT_MOD;
      for (int ch = 0; ch < NUM_CH; ch++) m_ticks[ch] = nt[ch];
    end
  endtask

  task automatic test_reset();
    int rise;
    rst = 1'b1; locked = 1'b0; enable = 1'b0; mode = '0; duty = '0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (led !== '0) begin errors++; $display("FAIL reset_led led=%b expected=00", led); end
      checks++;
      if (running !== 1'b0) begin errors++; $display("FAIL reset_running running=%b expected=0", running); end
    end
    rst = 1'b0; locked = 1'b1; enable = 1'b1; mode = 4'b0101;
    rise = 0;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      if (running === 1'b1 && rise == 0) rise = k;
      checks++;
      if (running !== m_running || led !== m_led) begin
        errors++;
        $display("FAIL lock_sync running=%b led=%b expected running=%b led=%b", running, led, m_running, m_led);
      end
    end
    checks++;
    if (rise != 3) begin errors++; $display("FAIL running_latency got=%0d expected=3", rise); end
  endtask

  task automatic test_blink();
    logic [NUM_CH-1:0] prev;
    int tog0, tog1;
    mode = 4'b0101;
    prev = led; tog0 = 0; tog1 = 0;
    for (int k = 0; k < 128; k++) begin
      cycle();
      checks++;
      if (led !== m_led) begin errors++; $display("FAIL blink led=%b expected=%b", led, m_led); end
      if (led[0] != prev[0]) tog0++;
      if (led[1] != prev[1]) tog1++;
      prev = led;
    end
    checks++;
    if (tog0 != 4) begin errors++; $display("FAIL blink_ch0_toggles got=%0d expected=4", tog0); end
    checks++;
    if (tog1 != 8) begin errors++; $display("FAIL blink_ch1_toggles got=%0d expected=8", tog1); end
  endtask

  task automatic test_pwm();
    int dl[4];
    int hi;
    dl[0] = 3; dl[1] = 0; dl[2] = 7; dl[3] = int'($urandom_range(1, 6));
    mode = 4'b1010;
    for (int j = 0; j < 4; j++) begin
      duty[2:0] = 3'(dl[j]);
      duty[5:3] = 3'($urandom_range(0, 7));
      for (int k = 0; k < 8; k++) begin
        cycle();
        checks++;
        if (led !== m_led) begin errors++; $display("FAIL pwm_settle duty=%0d led=%b expected=%b", dl[j], led, m_led); end
      end
      hi = 0;
      for (int k = 0; k < 8; k++) begin
        cycle();
        if (led[0]) hi++;
        checks++;
        if (led !== m_led) begin errors++; $display("FAIL pwm duty=%0d led=%b expected=%b", dl[j], led, m_led); end
      end
      checks++;
      if (hi != dl[j]) begin errors++; $display("FAIL pwm_high_count got=%0d expected=%0d", hi, dl[j]); end
    end
  endtask

  task automatic test_breathe();
    mode = 4'b1000;
    cycle();
    mode = 4'b1100;
    for (int k = 0; k < 130; k++) begin
      cycle();
      checks++;
      if (led !== m_led) begin
        errors++;
        $display("FAIL breathe ticks=%0d led=%b expected=%b", m_ticks[1], led, m_led);
      end
    end
  endtask

  task automatic test_lock_loss();
    int budget;
    int frozen;
    mode = 4'b1000;
    cycle();
    mode = 4'b1100;
    budget = 0;
    while (m_ticks[1] != 5 && budget < 200) begin
      cycle();
      budget++;
      checks++;
      if (led !== m_led) begin errors++; $display("FAIL pre_lockloss led=%b expected=%b", led, m_led); end
    end
    checks++;
    if (m_ticks[1] != 5) begin errors++; $display("FAIL lockloss_reach_level5 ticks=%0d expected=5", m_ticks[1]); end
    locked = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      checks++;
      if (led !== m_led) begin errors++; $display("FAIL lockloss led=%b expected=%b", led, m_led); end
      if (k >= 3) begin
        checks++;
        if (led !== '0 || running !== 1'b0) begin
          errors++;
          $display("FAIL lockloss_dark led=%b running=%b expected led=00 running=0", led, running);
        end
      end
    end
    frozen = m_ticks[1];
    locked = 1'b1;
    for (int k = 0; k < 60; k++) begin
      cycle();
      checks++;
      if (led !== m_led || running !== m_running) begin
        errors++;
        $display("FAIL relock frozen_ticks=%0d led=%b expected=%b", frozen, led, m_led);
      end
    end
  endtask

  task automatic test_mode_reset();
    mode = 4'b1100;
    for (int k = 0; k < 30; k++) begin
      cycle();
      checks++;
      if (led !== m_led) begin errors++; $display("FAIL mode_breathe1 led=%b expected=%b", led, m_led); end
    end
    mode = 4'b1000;
    duty[5:3] = 3'd4;
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks++;
      if (led !== m_led) begin errors++; $display("FAIL mode_pwm led=%b expected=%b", led, m_led); end
    end
    mode = 4'b1100;
    for (int k = 0; k < 40; k++) begin
      cycle();
      checks++;
      if (led !== m_led) begin errors++; $display("FAIL mode_breathe2 led=%b expected=%b", led, m_led); end
    end
    rst = 1'b1;
    cycle();
    checks++;
    if (led !== '0 || running !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset led=%b running=%b expected led=00 running=0", led, running);
    end
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      checks++;
      if (led !== m_led || running !== m_running) begin
        errors++;
        $display("FAIL post_reset led=%b running=%b expected led=%b running=%b", led, running, m_led, m_running);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 19) == 0) mode = 4'($urandom);
      if ($urandom_range(0, 19) == 0) duty = 6'($urandom);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 59) == 0) locked = ~locked;
      cycle();
      checks++;
      if (led !== m_led || running !== m_running) begin
        errors++;
        $display("FAIL random k=%0d led=%b running=%b expected led=%b running=%b", k, led, running, m_led, m_running);
      end
    end
  endtask

  initial begin
    m_n = 0; m_lk1 = 0; m_lk2 = 0; m_led = '0; m_running = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) m_ticks[ch] = 0;
    test_reset();
    test_blink();
    test_pwm();
    test_breathe();
    test_lock_loss();
    test_mode_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
